wb_cmd_master: RTL and testbench
================================

Name: wb_cmd_master

Overview:
- Wishbone classic single-access bus master. It is the initiator counterpart of the wbs_* responder port that each wrapped project exposes.
- A simple valid/ready command channel is turned into one Wishbone read or write cycle. The result comes back on a valid/ready response channel.
- Used in project test harnesses and in logic-analyzer-driven bring-up to exercise a project's Wishbone slave without the management core.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles stb may stay high without ack before the transfer is aborted with an error. 0 disables the timeout.
- ERR_DATA, 32'hDEAD_BEEF: value driven on rsp_dat when a transfer times out.

Ports:
- wb_clk_i  input  1  clock; all logic on the rising edge
- wb_rst_i  input  1  reset, asynchronous, active-high
- cmd_valid  input  1  command present
- cmd_ready  output  1  block can accept a command
- cmd_we  input  1  1 = write, 0 = read
- cmd_adr  input  32  byte address
- cmd_dat  input  32  write data
- cmd_sel  input  4  byte lane selects
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts response
- rsp_dat  output  32  read data; cmd_dat echo on write; ERR_DATA on timeout
- rsp_err  output  1  1 = transfer timed out
- wbm_cyc_o  output  1  Wishbone cycle
- wbm_stb_o  output  1  Wishbone strobe
- wbm_we_o  output  1  Wishbone write enable
- wbm_sel_o  output  4  Wishbone byte selects
- wbm_adr_o  output  32  Wishbone address
- wbm_dat_o  output  32  Wishbone write data
- wbm_ack_i  input  1  Wishbone acknowledge
- wbm_dat_i  input  32  Wishbone read data

Behaviour:
- Reset values: all outputs 0 except cmd_ready = 1. State is IDLE and the timeout counter is 0. Reset asserted mid-transfer drops cyc/stb immediately (asynchronous); the transfer is lost and no response is produced.
- Every output is registered except cmd_ready, which is decoded directly from state == IDLE.
- State machine:
  - IDLE: cmd_ready = 1. On cmd_valid & cmd_ready, latch we/adr/dat/sel into the wbm_* output registers, set cyc = stb = 1, clear the counter, go to BUS.
  - BUS: cyc = stb = 1 and all wbm_* fields held stable.
    - wbm_ack_i = 1 in any BUS cycle, including the first: next edge sets cyc = stb = 0. rsp_dat takes wbm_dat_i on a read or wbm_dat_o on a write. rsp_err = 0, rsp_valid = 1, go to RESP.
    - Otherwise the counter increments. When the counter == TIMEOUT_CYCLES-1 and there is still no ack (TIMEOUT_CYCLES > 0): next edge sets cyc = stb = 0, rsp_dat = ERR_DATA, rsp_err = 1, rsp_valid = 1, go to RESP.
    - With TIMEOUT_CYCLES = 0 the block waits indefinitely.
    - If ack and timeout occur in the same cycle, ack wins.
  - RESP: hold rsp_valid/rsp_dat/rsp_err until rsp_ready = 1. The edge where rsp_valid & rsp_ready clears rsp_valid and rsp_err and returns to IDLE. rsp_dat keeps its value. cmd_ready stays 0 throughout RESP.
- Timing: command accepted at edge N; stb is high from edge N through the cycle ack arrives. With ack sampled at edge N+k (k ≥ 1), rsp_valid is high after edge N+k. Minimum command-to-command spacing is 3 cycles when the slave acks in the first stb cycle and rsp_ready is held high.
- wbm_ack_i is ignored outside BUS, including spurious acks in IDLE and RESP.
- Only one transaction is outstanding; there is no pipelining or burst support.
- Counter width is $clog2(TIMEOUT_CYCLES+1) with a minimum of 1; it never wraps, because the timeout fires first.
- wbm_dat_o, wbm_adr_o, wbm_sel_o and wbm_we_o keep their last values after a transfer. Only cyc/stb are guaranteed 0 outside BUS.

Test Plan:
- Write, slave acks in the first stb cycle: cmd we=1, adr=32'h3000_0004, dat=32'h1234_5678, sel=4'hF. Required: cyc/stb high for exactly 1 cycle with those values on the bus, then rsp_valid=1, rsp_err=0, rsp_dat=32'h1234_5678.
- Read, ack delayed 3 cycles, wbm_dat_i=32'hCAFE_0001: stb high for 4 cycles, then rsp_dat=32'hCAFE_0001, rsp_err=0. cmd_ready stays 0 until the response is accepted.
- Timeout, TIMEOUT_CYCLES=4, no ack: stb high for exactly 4 cycles, then drops. rsp_valid=1, rsp_err=1, rsp_dat=32'hDEAD_BEEF.
- Response backpressure: rsp_ready held 0 for 5 cycles. rsp_valid and rsp_dat stay stable and a new cmd_valid is not accepted. rsp_ready=1 returns the block to IDLE and cmd_ready=1 on the next cycle.
- Spurious ack: wbm_ack_i pulsed in IDLE and again in RESP. No state change and no extra response.
- Reset mid-BUS: wb_rst_i asserted 2 cycles into a stalled read. cyc/stb go to 0 without waiting for a clock edge, and rsp_valid=0. After release, cmd_ready=1 and a new write completes normally.

Source files
------------

// File: rtl/wb_cmd_master_if.sv
// Command, response and Wishbone signal bundle for wb_cmd_master.
// 'master' is the block's own view; 'slave' is the harness side that feeds commands and models the bus.
interface wb_cmd_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;

  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel,
    output cmd_ready,
    output rsp_valid, rsp_dat, rsp_err,
    input  rsp_ready,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_ack_i, wbm_dat_i
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel,
    input  cmd_ready,
    input  rsp_valid, rsp_dat, rsp_err,
    output rsp_ready,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_ack_i, wbm_dat_i
  );
endinterface

// File: rtl/wb_cmd_master.sv
// Wishbone classic single-access master: one valid/ready command becomes one read or
// write cycle, and its result or a timeout error is returned on a valid/ready response channel.
module wb_cmd_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  wb_cmd_master_if.master  bus
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit          TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;

  logic        cyc_q, cyc_nxt;
  logic        stb_q, stb_nxt;
  logic        we_q, we_nxt;
  logic [3:0]  sel_q, sel_nxt;
  logic [31:0] adr_q, adr_nxt;
  logic [31:0] dat_q, dat_nxt;

  logic        rsp_valid_q, rsp_valid_nxt;
  logic        rsp_err_q, rsp_err_nxt;
  logic [31:0] rsp_dat_q, rsp_dat_nxt;

  // State, counter and every output register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_dat_q   <= '0;
    end else begin
      state_q     <= state_nxt;
      cnt_q       <= cnt_nxt;
      cyc_q       <= cyc_nxt;
      stb_q       <= stb_nxt;
      we_q        <= we_nxt;
      sel_q       <= sel_nxt;
      adr_q       <= adr_nxt;
      dat_q       <= dat_nxt;
      rsp_valid_q <= rsp_valid_nxt;
      rsp_err_q   <= rsp_err_nxt;
      rsp_dat_q   <= rsp_dat_nxt;
    end
  end

  // Next-state and next-output decode; every register holds unless a transition updates it.
  always_comb begin
    state_nxt     = state_q;
    cnt_nxt       = cnt_q;
    cyc_nxt       = cyc_q;
    stb_nxt       = stb_q;
    we_nxt        = we_q;
    sel_nxt       = sel_q;
    adr_nxt       = adr_q;
    dat_nxt       = dat_q;
    rsp_valid_nxt = rsp_valid_q;
    rsp_err_nxt   = rsp_err_q;
    rsp_dat_nxt   = rsp_dat_q;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          we_nxt    = bus.cmd_we;
          sel_nxt   = bus.cmd_sel;
          adr_nxt   = bus.cmd_adr;
          dat_nxt   = bus.cmd_dat;
          cyc_nxt   = 1'b1;
          stb_nxt   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = BUS;
        end
      end

      BUS: begin
        // Ack takes priority over a timeout expiring in the same cycle.
        if (bus.wbm_ack_i) begin
          cyc_nxt       = 1'b0;
          stb_nxt       = 1'b0;
          rsp_dat_nxt   = we_q ? dat_q : bus.wbm_dat_i;
          rsp_err_nxt   = 1'b0;
          rsp_valid_nxt = 1'b1;
          state_nxt     = RESP;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          cyc_nxt       = 1'b0;
          stb_nxt       = 1'b0;
          rsp_dat_nxt   = ERR_DATA;
          rsp_err_nxt   = 1'b1;
          rsp_valid_nxt = 1'b1;
          state_nxt     = RESP;
        end else if (TO_EN) begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end

      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          rsp_err_nxt   = 1'b0;
          state_nxt     = IDLE;
        end
      end

      default: begin
        cyc_nxt   = 1'b0;
        stb_nxt   = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.cmd_ready = (state_q == IDLE);

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_dat   = rsp_dat_q;

  assign bus.wbm_cyc_o = cyc_q;
  assign bus.wbm_stb_o = stb_q;
  assign bus.wbm_we_o  = we_q;
  assign bus.wbm_sel_o = sel_q;
  assign bus.wbm_adr_o = adr_q;
  assign bus.wbm_dat_o = dat_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: directed scenarios plus random transactions, each predicted
// from the ack delay alone (ack before the timeout budget completes the access, otherwise an error).
module tb_wb_cmd_master;

  localparam int unsigned TO  = 4;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_cmd_master_if bus ();

  wb_cmd_master #(.TIMEOUT_CYCLES(TO), .ERR_DATA(ERR)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One complete transaction. delay = stb cycles without ack before the ack cycle
  // (delay >= TO means the slave never acks in time); hold = cycles of response backpressure.
  task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int delay, input logic [31:0] rdata,
                         input int hold, input bit ack_in_resp);
    bit          timed_out;
    int          exp_n;
    int          n;
    logic [31:0] exp_dat;
    timed_out = (delay >= int'(TO));
    exp_n     = timed_out ? int'(TO) : delay + 1;
    exp_dat   = timed_out ? ERR : (we ? dat : rdata);

    @(negedge clk);
    check("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = we;
    bus.cmd_adr   = adr;
    bus.cmd_dat   = dat;
    bus.cmd_sel   = sel;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_adr   = $urandom;
    bus.cmd_dat   = $urandom;
    bus.cmd_sel   = 4'($urandom);
    bus.cmd_we    = ~we;

    n = 0;
    while (bus.wbm_stb_o && n < 50) begin
      n++;
      check("bus_adr", bus.wbm_adr_o, adr);
      check("bus_dat", bus.wbm_dat_o, dat);
      check("bus_ctl", 32'({bus.cmd_ready, bus.wbm_cyc_o, bus.wbm_we_o, bus.wbm_sel_o}),
            32'({1'b0, 1'b1, we, sel}));
      if (n - 1 == delay) begin
        bus.wbm_ack_i = 1'b1;
        bus.wbm_dat_i = rdata;
      end else begin
        bus.wbm_ack_i = 1'b0;
        bus.wbm_dat_i = $urandom;
      end
      @(negedge clk);
    end
    bus.wbm_ack_i = 1'b0;

    check("stb_cycles", 32'(n), 32'(exp_n));
    check("rsp_flags", 32'({bus.rsp_valid, bus.rsp_err, bus.wbm_cyc_o}), 32'({1'b1, timed_out, 1'b0}));
    check("rsp_dat", bus.rsp_dat, exp_dat);

    // Backpressure: a new command is offered and must not be taken.
    for (int i = 0; i < hold; i++) begin
      bus.cmd_valid = 1'b1;
      bus.wbm_ack_i = ack_in_resp && (i == 0);
      @(negedge clk);
      check("resp_hold", 32'({bus.cmd_ready, bus.wbm_cyc_o, bus.wbm_stb_o, bus.rsp_valid, bus.rsp_err}),
            32'({1'b0, 1'b0, 1'b0, 1'b1, timed_out}));
      check("resp_hold_dat", bus.rsp_dat, exp_dat);
    end
    bus.wbm_ack_i = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("after_accept", 32'({bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.wbm_stb_o}),
          32'({1'b1, 1'b0, 1'b0, 1'b0}));
    check("rsp_dat_keep", bus.rsp_dat, exp_dat);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_we    = 1'b0;
    bus.cmd_adr   = '0;
    bus.cmd_dat   = '0;
    bus.cmd_sel   = '0;
    bus.rsp_ready = 1'b0;
    bus.wbm_ack_i = 1'b0;
    bus.wbm_dat_i = '0;

    // Reset values.
    @(negedge clk);
    @(negedge clk);
    check("rst_ctl", 32'({bus.cmd_ready, bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o,
                          bus.rsp_valid, bus.rsp_err}), 32'({1'b1, 3'b000, 4'h0, 2'b00}));
    check("rst_adr", bus.wbm_adr_o, 32'h0);
    check("rst_dat", bus.wbm_dat_o, 32'h0);
    check("rst_rsp_dat", bus.rsp_dat, 32'h0);
    rst = 1'b0;

    // Directed: immediate-ack write, delayed read, timeout, backpressure with spurious ack.
    run_txn(1'b1, 32'h3000_0004, 32'h1234_5678, 4'hF, 0, 32'h0, 0, 1'b0);
    run_txn(1'b0, 32'h3000_0010, 32'h5555_AAAA, 4'h3, 3, 32'hCAFE_0001, 0, 1'b0);
    run_txn(1'b0, 32'h3000_0020, 32'h0, 4'hF, 100, 32'h0, 0, 1'b0);
    run_txn(1'b1, 32'h3000_0030, 32'h0BAD_F00D, 4'h1, 1, 32'h0, 5, 1'b1);

    // Spurious ack while idle.
    @(negedge clk);
    bus.wbm_ack_i = 1'b1;
    bus.wbm_dat_i = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.wbm_ack_i = 1'b0;
    check("idle_ack", 32'({bus.cmd_ready, bus.wbm_cyc_o, bus.wbm_stb_o, bus.rsp_valid}), 32'(4'b1000));

    // Reset during a stalled read: cyc/stb must drop without a clock edge.
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = 1'b0;
    bus.cmd_adr   = 32'h3000_0040;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_stb", 32'(bus.wbm_stb_o), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst", 32'({bus.wbm_cyc_o, bus.wbm_stb_o, bus.rsp_valid, bus.cmd_ready}), 32'(4'b0001));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst", 32'({bus.cmd_ready, bus.rsp_valid, bus.wbm_stb_o}), 32'(3'b100));
    run_txn(1'b1, 32'h3000_0044, 32'hA5A5_0F0F, 4'hC, 0, 32'h0, 0, 1'b0);

    // Random transactions; delays straddle the timeout boundary.
    for (int t = 0; t < 40; t++) begin
      run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom), int'($urandom_range(0, 6)),
              $urandom, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
